coin_acceptor: RTL and testbench

- Front-end coin conditioner that sits directly upstream of the vending-machine FSM.
- Turns two raw, asynchronous, bouncy coin-sensor lines into a clean one-cycle `coin[1:0]` code: 2'b01 = one-unit coin, 2'b10 = two-unit coin, 2'b00 = none.
- Uses per-channel synchronisation, debounce, insertion arbitration, reject signalling and sensor-jam detection.
- `coin` connects directly to the FSM's `coin` input.

---
 rtl/coin_acceptor.sv | 132 +++++++++++++
 tb/tb_coin_acceptor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-sensor conditioner: synchronises, debounces and arbitrates two raw coin
// sensors into a one-cycle coin code, with reject pulses and a sticky jam flag.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned JAM_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       sense_1,
    input  logic       sense_2,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam int unsigned DB_W  = 8;
    localparam int unsigned JAM_W = $clog2(JAM_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [JAM_W-1:0] JAM_MAX = JAM_W'(JAM_CYCLES);

    typedef enum logic {
        IDLE         = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    // Bit 0 is the one-unit channel, bit 1 the two-unit channel.
    logic [1:0]      meta_q;
    logic [1:0]      s_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_prev_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      rise;

    logic [JAM_W-1:0] jcnt_q, jcnt_d;
    logic             jam_q, jam_d;

    state_t     state_q, state_d;
    logic [1:0] coin_q, coin_d;
    logic       reject_q, reject_d;

    // Debounce: a level flips only after DEBOUNCE consecutive mismatching edges.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (s_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    // Jam counter saturates at JAM_MAX so the flag sets exactly once.
    always_comb begin
        jcnt_d = '0;
        if (|deb_q) begin
            jcnt_d = (jcnt_q == JAM_MAX) ? jcnt_q : jcnt_q + JAM_W'(1);
        end
        jam_d = jam_q | (jcnt_d == JAM_MAX);
    end

    always_comb begin
        state_d  = state_q;
        coin_d   = 2'b00;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    state_d = WAIT_RELEASE;
                    if (!jam_q) begin
                        if ((rise == 2'b11) || !accept_en) begin
                            reject_d = 1'b1;
                        end else begin
                            coin_d = rise;
                        end
                    end
                end
            end
            WAIT_RELEASE: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end else if (|rise) begin
                    reject_d = 1'b1;
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // Debounced levels reset high so a sensor held through reset is never credited.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            meta_q     <= 2'b00;
            s_q        <= 2'b00;
            deb_q      <= 2'b11;
            deb_prev_q <= 2'b11;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            jcnt_q     <= '0;
            jam_q      <= 1'b0;
            state_q    <= WAIT_RELEASE;
            coin_q     <= 2'b00;
            reject_q   <= 1'b0;
        end else begin
            meta_q     <= {sense_2, sense_1};
            s_q        <= meta_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            jcnt_q     <= jcnt_d;
            jam_q      <= jam_d;
            state_q    <= state_d;
            coin_q     <= coin_d;
            reject_q   <= reject_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DEBOUNCE=4, JAM_CYCLES=50).
module tb_coin_acceptor;

    logic       clock;
    logic       rst;
    logic       sense_1;
    logic       sense_2;
    logic       accept_en;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int mon_c1 = 0, mon_c2 = 0, mon_rj = 0, mon_bad = 0;
    int b1, b2, br;

    coin_acceptor #(.DEBOUNCE(4), .JAM_CYCLES(50)) dut (
        .clock     (clock),
        .rst       (rst),
        .sense_1   (sense_1),
        .sense_2   (sense_2),
        .accept_en (accept_en),
        .coin      (coin),
        .reject    (reject),
        .jam       (jam),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse tally sampled on the falling edge.
    always @(negedge clock) begin
        if (coin == 2'b01) mon_c1++;
        if (coin == 2'b10) mon_c2++;
        if (reject) mon_rj++;
        if ((coin == 2'b11) || ((coin != 2'b00) && reject)) mon_bad++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b1 = mon_c1;
        b2 = mon_c2;
        br = mon_rj;
    endtask

    task automatic chk_pulses(input string tag, input int e1, input int e2, input int er);
        chk({tag, "_coin01"}, mon_c1 - b1, e1);
        chk({tag, "_coin10"}, mon_c2 - b2, e2);
        chk({tag, "_reject"}, mon_rj - br, er);
    endtask

    initial begin
        rst = 1'b1; sense_1 = 1'b0; sense_2 = 1'b0; accept_en = 1'b1;
        #3;
        chk("rst_coin", int'(coin), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_jam", int'(jam), 0);
        chk("rst_busy", int'(busy), 1);
        step(2);
        rst = 1'b0;
        step(10);
        chk("idle_after_rst", int'(busy), 0);

        // Clean one-unit coin
        snap();
        sense_1 = 1'b1;
        step(6);
        chk("c1_edge6", int'(coin), 0);
        step(1);
        chk("c1_edge7", int'(coin), 1);
        chk("c1_busy", int'(busy), 1);
        step(1);
        chk("c1_edge8", int'(coin), 0);
        step(12);
        sense_1 = 1'b0;
        step(6);
        chk("c1_busy_rel6", int'(busy), 1);
        step(1);
        chk("c1_idle_rel7", int'(busy), 0);
        chk_pulses("c1", 1, 0, 0);

        // Bounce on sense_2
        snap();
        for (int k = 0; k < 3; k++) begin
            sense_2 = 1'b1;
            step(2);
            sense_2 = 1'b0;
            step(2);
        end
        sense_2 = 1'b1;
        step(6);
        chk("bnc_edge6", int'(coin), 0);
        step(1);
        chk("bnc_edge7", int'(coin), 2);
        step(3);
        sense_2 = 1'b0;
        step(10);
        chk_pulses("bnc", 0, 1, 0);

        // Simultaneous sensors
        snap();
        sense_1 = 1'b1; sense_2 = 1'b1;
        step(6);
        chk("sim_edge6", int'(reject), 0);
        step(1);
        chk("sim_edge7_rej", int'(reject), 1);
        chk("sim_edge7_coin", int'(coin), 0);
        step(1);
        chk("sim_edge8", int'(reject), 0);
        step(5);
        sense_1 = 1'b0; sense_2 = 1'b0;
        step(10);
        chk_pulses("sim", 0, 0, 1);

        // Disabled acceptance
        snap();
        accept_en = 1'b0;
        sense_1 = 1'b1;
        step(7);
        chk("dis_rej", int'(reject), 1);
        chk("dis_coin", int'(coin), 0);
        step(5);
        sense_1 = 1'b0;
        accept_en = 1'b1;
        step(10);
        chk_pulses("dis", 0, 0, 1);

        // Overlap: sense_2 arrives while sense_1 still held
        snap();
        sense_1 = 1'b1;
        step(7);
        chk("ovl_coin", int'(coin), 1);
        step(3);
        sense_2 = 1'b1;
        step(7);
        chk("ovl_rej", int'(reject), 1);
        chk("ovl_rej_coin", int'(coin), 0);
        step(1);
        chk("ovl_rej_end", int'(reject), 0);
        step(3);
        sense_1 = 1'b0; sense_2 = 1'b0;
        step(10);
        chk("ovl_idle", int'(busy), 0);
        chk_pulses("ovl", 1, 0, 1);

        // Jam: deb_1 high after edge 6, jam sets at edge 56
        snap();
        sense_1 = 1'b1;
        step(7);
        chk("jam_coin", int'(coin), 1);
        step(48);
        chk("jam_edge55", int'(jam), 0);
        step(1);
        chk("jam_edge56", int'(jam), 1);
        step(4);
        sense_1 = 1'b0;
        step(10);
        chk("jam_sticky", int'(jam), 1);
        chk("jam_idle", int'(busy), 0);
        sense_2 = 1'b1;
        step(7);
        chk("jam_s2_coin", int'(coin), 0);
        chk("jam_s2_rej", int'(reject), 0);
        step(5);
        sense_2 = 1'b0;
        step(10);
        chk("jam_still", int'(jam), 1);
        chk_pulses("jam", 1, 0, 0);

        rst = 1'b1;
        step(1);
        chk("jam_rst_clr", int'(jam), 0);
        rst = 1'b0;
        step(10);

        // Async reset while a coin pulse is on the output
        sense_1 = 1'b1;
        step(7);
        chk("ar_pre_coin", int'(coin), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_coin_clr", int'(coin), 0);
        chk("ar_rej_clr", int'(reject), 0);
        chk("ar_busy", int'(busy), 1);
        step(1);
        rst = 1'b0;
        snap();
        step(30);
        chk("ar_busy_held", int'(busy), 1);
        chk_pulses("ar_held", 0, 0, 0);
        sense_1 = 1'b0;
        step(6);
        snap();
        sense_1 = 1'b1;
        step(6);
        chk("ar_fresh_e6", int'(coin), 0);
        step(1);
        chk("ar_fresh_e7", int'(coin), 1);
        step(5);
        sense_1 = 1'b0;
        step(10);
        chk("ar_idle", int'(busy), 0);
        chk_pulses("ar_fresh", 1, 0, 0);

        chk("no_overlap_or_11", mon_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
